// File: rtl/terrain_pkg.sv
// ---------------------------------------------------------------------------
// terrain_pkg
// Shared types and constants for the terrain scheduler: scan FSM states,
// the obstacle table entry layout and the "no block ahead" marker.
// Entry field widths are fixed here; the scheduler's MAP_W / POS_DIGIT
// parameters must stay equal to TERR_MAP_W / TERR_POS_DIGIT.
// ---------------------------------------------------------------------------
package terrain_pkg;

   localparam int TERR_MAP_W     = 20;
   localparam int TERR_POS_DIGIT = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   typedef struct packed {
      logic                      valid;
      logic [TERR_MAP_W-1:0]     left;    // inclusive world x
      logic [TERR_MAP_W-1:0]     right;   // exclusive world x
      logic [TERR_POS_DIGIT-1:0] height;  // above screen bottom
   } blk_entry_t;

   // Edge value reported when no block lies ahead of the character.
   localparam logic [TERR_MAP_W-1:0] NO_BLK = '1;

   // An entry only describes a real block when it is valid and non-empty.
   function automatic logic entry_usable(input blk_entry_t e);
      return e.valid && (e.left < e.right);
   endfunction

endpackage

// File: rtl/terrain_blk_table.sv
// ---------------------------------------------------------------------------
// terrain_blk_table
// Register-file obstacle table: one synchronous write port, a global clear
// of the valid bits and a combinational read port addressed by the scanner.
//
// Ports:
//   i_clk_pix   pixel clock
//   i_rst_n     asynchronous active-low reset (clears valid bits only)
//   i_we        write strobe (already qualified by the caller)
//   i_clear     invalidate all entries; wins over i_we
//   i_addr      write index
//   i_wr_entry  entry written at i_addr
//   i_rd_idx    read index
//   o_rd_entry  entry stored at i_rd_idx
// ---------------------------------------------------------------------------
module terrain_blk_table
   import terrain_pkg::*;
#(
   parameter int NUM_BLK = 8,
   parameter int AW      = $clog2(NUM_BLK)
) (
   input  logic          i_clk_pix,
   input  logic          i_rst_n,
   input  logic          i_we,
   input  logic          i_clear,
   input  logic [AW-1:0] i_addr,
   input  blk_entry_t    i_wr_entry,
   input  logic [AW-1:0] i_rd_idx,
   output blk_entry_t    o_rd_entry
);

   logic [NUM_BLK-1:0]        valid_q;
   logic [TERR_MAP_W-1:0]     left_q   [NUM_BLK];
   logic [TERR_MAP_W-1:0]     right_q  [NUM_BLK];
   logic [TERR_POS_DIGIT-1:0] height_q [NUM_BLK];

   // Valid bits are the only state that needs a defined reset value; the
   // geometry fields are meaningless while their valid bit is clear.
   always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q <= '0;
      end else if (i_clear) begin
         valid_q <= '0;
      end else if (i_we) begin
         valid_q[i_addr] <= i_wr_entry.valid;
      end
   end

   always_ff @(posedge i_clk_pix) begin
      if (i_we && !i_clear) begin
         left_q[i_addr]   <= i_wr_entry.left;
         right_q[i_addr]  <= i_wr_entry.right;
         height_q[i_addr] <= i_wr_entry.height;
      end
   end

   always_comb begin
      o_rd_entry        = '0;
      o_rd_entry.valid  = valid_q[i_rd_idx];
      o_rd_entry.left   = left_q[i_rd_idx];
      o_rd_entry.right  = right_q[i_rd_idx];
      o_rd_entry.height = height_q[i_rd_idx];
   end

endmodule

// File: rtl/terrain_scheduler.sv
// ---------------------------------------------------------------------------
// terrain_scheduler
// Per-frame scheduler for the character position datapath's terrain inputs.
// On a frame pulse it snapshots the character's world span [cl, cr), scans
// the obstacle table one entry per clock, and on the last scan cycle loads
// the floor height and the nearest block ahead into the output registers,
// so they change exactly once per frame while o_done is high.
//
// Ports:
//   i_clk_pix, i_rst_n          clock, asynchronous active-low reset
//   i_frame                     one-cycle frame-start pulse
//   i_map_x                     map scroll offset (world x of screen x=0)
//   i_char_pos, i_spr_width     character screen x and sprite width
//   i_cfg_*                     table write / clear port
//   o_cfg_ready                 table accepts writes/clear (not busy)
//   o_busy                      scan or commit in progress
//   o_done                      one-cycle pulse when outputs update
//   o_overrun                   sticky: frame pulse arrived while busy
//   o_floor                     floor height for the datapath
//   o_blk_left/right/height     nearest block ahead (edges all ones if none)
// ---------------------------------------------------------------------------
module terrain_scheduler
   import terrain_pkg::*;
#(
   parameter int NUM_BLK    = 8,
   parameter int MAP_W      = TERR_MAP_W,
   parameter int POS_DIGIT  = TERR_POS_DIGIT,
   parameter int BASE_FLOOR = 40,
   localparam int AW        = $clog2(NUM_BLK)
) (
   input  logic                        i_clk_pix,
   input  logic                        i_rst_n,
   input  logic                        i_frame,
   input  logic [MAP_W-1:0]            i_map_x,
   input  logic [POS_DIGIT-1:0]        i_char_pos,
   input  logic [POS_DIGIT-1:0]        i_spr_width,
   input  logic                        i_cfg_we,
   input  logic [AW-1:0]               i_cfg_addr,
   input  logic                        i_cfg_valid,
   input  logic [MAP_W-1:0]            i_cfg_left,
   input  logic [MAP_W-1:0]            i_cfg_right,
   input  logic [POS_DIGIT-1:0]        i_cfg_height,
   input  logic                        i_cfg_clear,
   output logic                        o_cfg_ready,
   output logic                        o_busy,
   output logic                        o_done,
   output logic                        o_overrun,
   output logic signed [POS_DIGIT-1:0] o_floor,
   output logic [MAP_W-1:0]            o_blk_left,
   output logic [MAP_W-1:0]            o_blk_right,
   output logic [POS_DIGIT-1:0]        o_blk_height
);

   localparam logic [AW-1:0]        LAST_IDX   = AW'(NUM_BLK - 1);
   localparam logic [POS_DIGIT-1:0] FLOOR_RST  = POS_DIGIT'(BASE_FLOOR);

   state_t                 state_q, state_nxt;
   logic [AW-1:0]          idx_q;
   logic [MAP_W-1:0]       cl_q, cr_q;
   logic [POS_DIGIT-1:0]   floor_acc_q;
   logic [MAP_W-1:0]       best_left_q, best_right_q;
   logic [POS_DIGIT-1:0]   best_h_q;

   logic [MAP_W-1:0]       cl_snap, cr_snap;
   logic                   start, last_scan;
   logic                   ent_ok, overlap, ahead;
   logic [POS_DIGIT-1:0]   floor_nxt;
   logic [MAP_W-1:0]       best_left_nxt, best_right_nxt;
   logic [POS_DIGIT-1:0]   best_h_nxt;
   blk_entry_t             rd_entry, wr_entry;

   assign o_busy      = (state_q != IDLE);
   assign o_cfg_ready = !o_busy;
   assign o_done      = (state_q == COMMIT);
   assign start       = (state_q == IDLE) && i_frame;
   assign last_scan   = (state_q == SCAN) && (idx_q == LAST_IDX);

   always_comb begin
      wr_entry        = '0;
      wr_entry.valid  = i_cfg_valid;
      wr_entry.left   = i_cfg_left;
      wr_entry.right  = i_cfg_right;
      wr_entry.height = i_cfg_height;
   end

   // Config traffic is dropped while a scan is running so the table is
   // stable for the whole frame's evaluation.
   terrain_blk_table #(
      .NUM_BLK (NUM_BLK),
      .AW      (AW)
   ) u_table (
      .i_clk_pix  (i_clk_pix),
      .i_rst_n    (i_rst_n),
      .i_we       (i_cfg_we && o_cfg_ready),
      .i_clear    (i_cfg_clear && o_cfg_ready),
      .i_addr     (i_cfg_addr),
      .i_wr_entry (wr_entry),
      .i_rd_idx   (idx_q),
      .o_rd_entry (rd_entry)
   );

   // Character world span; screen position is zero-extended, wrap ignored.
   assign cl_snap = MAP_W'(i_char_pos) + i_map_x;
   assign cr_snap = cl_snap + MAP_W'(i_spr_width);

   // Per-entry evaluation against the running accumulators. Overlap and
   // ahead are mutually exclusive since ahead requires left >= cr.
   always_comb begin
      ent_ok         = entry_usable(rd_entry);
      overlap        = ent_ok && (rd_entry.left < cr_q) && (rd_entry.right > cl_q);
      ahead          = ent_ok && (rd_entry.left >= cr_q) && (rd_entry.left < best_left_q);
      floor_nxt      = floor_acc_q;
      best_left_nxt  = best_left_q;
      best_right_nxt = best_right_q;
      best_h_nxt     = best_h_q;
      if (overlap && (rd_entry.height > floor_acc_q)) begin
         floor_nxt = rd_entry.height;
      end
      if (ahead) begin
         best_left_nxt  = rd_entry.left;
         best_right_nxt = rd_entry.right;
         best_h_nxt     = rd_entry.height;
      end
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:    if (i_frame) state_nxt = SCAN;
         SCAN:    if (idx_q == LAST_IDX) state_nxt = COMMIT;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         o_overrun <= 1'b0;
      end else begin
         state_q <= state_nxt;
         if (start) begin
            idx_q <= '0;
         end else if (state_q == SCAN) begin
            idx_q <= idx_q + AW'(1);
         end
         if (i_frame && o_busy) begin
            o_overrun <= 1'b1;
         end
      end
   end

   // Span snapshot and accumulators: always re-initialised at frame start.
   always_ff @(posedge i_clk_pix) begin
      if (start) begin
         cl_q         <= cl_snap;
         cr_q         <= cr_snap;
         floor_acc_q  <= FLOOR_RST;
         best_left_q  <= NO_BLK;
         best_right_q <= NO_BLK;
         best_h_q     <= '0;
      end else if (state_q == SCAN) begin
         floor_acc_q  <= floor_nxt;
         best_left_q  <= best_left_nxt;
         best_right_q <= best_right_nxt;
         best_h_q     <= best_h_nxt;
      end
   end

   // Outputs load with the final entry folded in, so they become visible in
   // the COMMIT cycle together with o_done.
   always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_floor      <= FLOOR_RST;
         o_blk_left   <= NO_BLK;
         o_blk_right  <= NO_BLK;
         o_blk_height <= '0;
      end else if (last_scan) begin
         o_floor      <= floor_nxt;
         o_blk_left   <= best_left_nxt;
         o_blk_right  <= best_right_nxt;
         o_blk_height <= best_h_nxt;
      end
   end

endmodule

// File: doc/terrain_scheduler.md
Name: terrain_scheduler

Overview:
- Per-frame scheduler that configures the terrain inputs of the character position datapath: floor, next-block left/right edges and next-block height.
- Holds a small programmable obstacle table in world (map) coordinates.
- On each frame pulse it scans the table one entry per clock against the character's world span, then commits a coherent set of outputs before the datapath's next frame update.

Parameters:
NUM_BLK, 8, number of obstacle table entries (power of 2, 2..32)
MAP_W, 20, width of world x coordinates (map scroll, block edges)
POS_DIGIT, 16, width of heights, floor and character screen position
BASE_FLOOR, 40, floor height used when no block overlaps the character

Ports:
i_clk_pix  in  1  pixel clock
i_rst_n  in  1  reset, asynchronous, active-low
i_frame  in  1  one-cycle frame-start pulse
i_map_x  in  MAP_W  current map scroll offset
i_char_pos  in  POS_DIGIT  character screen x
i_spr_width  in  POS_DIGIT  scaled sprite width
i_cfg_we  in  1  table write strobe
i_cfg_addr  in  $clog2(NUM_BLK)  entry index
i_cfg_valid  in  1  entry valid bit to write
i_cfg_left  in  MAP_W  block left edge (inclusive)
i_cfg_right  in  MAP_W  block right edge (exclusive)
i_cfg_height  in  POS_DIGIT  block height above screen bottom
i_cfg_clear  in  1  invalidate all entries
o_cfg_ready  out  1  table accepts writes/clear
o_busy  out  1  scan in progress
o_done  out  1  one-cycle pulse when outputs update
o_overrun  out  1  sticky: frame pulse arrived while busy
o_floor  out  POS_DIGIT  signed floor for the datapath
o_blk_left  out  MAP_W  nearest ahead block left edge
o_blk_right  out  MAP_W  nearest ahead block right edge
o_blk_height  out  POS_DIGIT  nearest ahead block height

Behaviour:
- Reset (asynchronous, any state): FSM to IDLE; all valid bits cleared; o_floor=BASE_FLOOR; o_blk_left and o_blk_right all ones; o_blk_height=0; o_done=0; o_busy=0; o_overrun=0. A scan in progress is aborted with no o_done.
- FSM states: IDLE, SCAN, COMMIT.
  - IDLE→SCAN on i_frame. In that same cycle, snapshot cl=i_char_pos+i_map_x and cr=cl+i_spr_width (MAP_W-bit, zero-extended, wrap ignored).
  - Also in that cycle, reset the accumulators: floor_acc=BASE_FLOOR, best_left=all ones, best_right=all ones, best_h=0, idx=0.
  - SCAN examines entry idx each cycle; idx increments. After idx=NUM_BLK-1 → COMMIT.
  - COMMIT copies the accumulators to the outputs, pulses o_done for 1 cycle, then returns to IDLE.
- Latency: i_frame at cycle 0 → entries scanned cycles 1..NUM_BLK → outputs and o_done valid at cycle NUM_BLK+1. Outputs hold between commits and never change mid-scan.
- Per valid entry (left<right required; an entry with left>=right is treated as invalid):
  - overlap if left<cr and right>cl: floor_acc=max(floor_acc,height) (unsigned compare).
  - ahead if left>=cr and left<best_left: best_* take this entry. Strict less-than means the lower index wins ties.
  - Blocks entirely behind the character (right<=cl) are ignored.
- o_busy=1 in SCAN and COMMIT. o_cfg_ready=!o_busy.
- Writes and clears are accepted only when o_cfg_ready=1; otherwise they are dropped silently.
- i_cfg_clear beats i_cfg_we in the same cycle.
- A table write takes effect the next cycle.
- i_frame while busy: ignored, and o_overrun set; it stays set until reset.
- Integration: the datapath's block-edge inputs take the low POS_DIGIT bits of o_blk_left/o_blk_right.

Decomposition:
- Package terrain_pkg: state enum (IDLE/SCAN/COMMIT), blk_entry_t struct {valid, left, right, height}, constant NO_BLK = all ones.
- Sub-module terrain_blk_table: register-file table with a write port, a clear input and a combinational read at idx. The scan FSM and accumulators stay in the top module.

Test Plan:
- Empty table (NUM_BLK=8): reset, then pulse i_frame → o_done at cycle 9; o_floor=40, o_blk_left=0xFFFFF, o_blk_height=0.
- Entry0 {300,360,80}, char_pos=200, width=57, map_x=0 → blk_left=300, right=360, height=80, floor=40. Then set map_x=60 and pulse frame → floor=80, blk_left=0xFFFFF.
- Nearest-ahead selection: entry3 left=500, entry5 left=400 (h=30) → blk_left=400, h=30. Add entry2 left=400, h=70 → h=70 (lower index wins the tie).
- Write entry1 while o_busy=1 → o_cfg_ready=0 and the write is dropped; the next scan shows the old entry1 contents. i_frame while busy → o_overrun=1 and stays set.
- Deassert i_rst_n at scan cycle 4 → outputs return to reset values immediately, no o_done pulse, and the table is empty afterwards.
- Same-cycle i_cfg_clear and i_cfg_we → all entries invalid, including the written index.
